// File: rtl/sample_bank_reader_pkg.sv
// Shared constants and types for the ping-pong sample buffer read side.
// The sample geometry is shared with sample_fifo, so both sides agree on frame size.
package sample_bank_reader_pkg;

  localparam int SAMPLE_W    = 8;
  localparam int NUM_SAMPLES = 512;
  localparam int SAMPLE_BITS = 9;

  // Address of the final sample in a frame; issuing it ends the sweep.
  localparam logic [SAMPLE_BITS-1:0] LAST_ADDR = SAMPLE_BITS'(NUM_SAMPLES - 1);

  // Reader sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // One buffered sample together with its end-of-frame tag.
  typedef struct packed {
    logic [SAMPLE_W-1:0] data;
    logic                last;
  } skid_entry_t;

endpackage

// File: rtl/sample_skid_buffer.sv
// Two-entry FIFO of {data, last} that absorbs the BRAM read latency.
// Entry 0 is always the head; a pop shifts entry 1 down. The occupancy count
// is exported so the reader can limit issue to what the buffer can hold.
module sample_skid_buffer
  import sample_bank_reader_pkg::*;
(
  input  logic                sys_clk,
  input  logic                rst,
  input  logic                i_push,
  input  logic [SAMPLE_W-1:0] i_data,
  input  logic                i_last,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [SAMPLE_W-1:0] o_data,
  output logic                o_last,
  output logic [1:0]          o_count
);

  skid_entry_t r_e0;
  skid_entry_t r_e1;
  logic [1:0]  r_count;
  logic        w_pop;
  logic        w_wr_hi;
  skid_entry_t w_entry;

  assign w_entry = '{data: i_data, last: i_last};
  assign w_pop   = (r_count != 2'd0) & i_ready;
  // After any pop, the new sample lands behind whatever remains at the head.
  assign w_wr_hi = (r_count == 2'd2) | ((r_count == 2'd1) & ~w_pop);

  // Storage shift on pop, write of incoming sample, occupancy tracking.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_e0    <= '{data: '0, last: 1'b0};
      r_e1    <= '{data: '0, last: 1'b0};
      r_count <= 2'd0;
    end else begin
      if (w_pop) begin
        r_e0 <= r_e1;
      end
      if (i_push) begin
        if (w_wr_hi) begin
          r_e1 <= w_entry;
        end else begin
          r_e0 <= w_entry;
        end
      end
      r_count <= r_count + {1'b0, i_push} - {1'b0, w_pop};
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_e0.data;
  assign o_last  = r_e0.last & o_valid;
  assign o_count = r_count;

endmodule

// File: rtl/sample_bank_reader.sv
// Read-side sequencer for the ping-pong ADC sample buffer.
// Each toggle of current_bank marks a full bank; the reader sweeps its addresses,
// hides the one-cycle BRAM latency with a credit-limited skid buffer and streams
// the frame out over valid/ready, flagging swaps that arrive mid-frame.
module sample_bank_reader
  import sample_bank_reader_pkg::*;
(
  input  logic                   sys_clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   current_bank,
  output logic [SAMPLE_BITS-1:0] read_address,
  input  logic [SAMPLE_W-1:0]    read_data,
  output logic [SAMPLE_W-1:0]    out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   out_bank,
  output logic                   busy,
  output logic                   overrun
);

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   r_bank_q;
  logic [SAMPLE_BITS-1:0] r_addr;
  logic                   r_inflight;
  logic                   r_inflight_last;
  logic                   r_out_bank;
  logic                   r_busy;
  logic                   r_overrun;

  logic                   w_swap;
  logic                   w_pop;
  logic                   w_credit;
  logic                   w_issue;
  logic                   w_start;
  logic                   w_done;
  logic [1:0]             w_count;
  logic [2:0]             w_occ;

  assign w_swap = current_bank ^ r_bank_q;
  assign w_pop  = out_valid & out_ready;
  // Occupancy the buffer will have after this cycle, before any new issue.
  // Counting the pop keeps a full-rate stream going with only two entries.
  assign w_occ    = {1'b0, w_count} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_credit = (w_occ <= 3'd1);

  // Sequencer state register.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state, issue and frame start/end decisions.
  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_start      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_swap & en) begin
          w_state_next = ST_READ;
          w_start      = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_READ: begin
        w_issue = en & w_credit;
        if (w_issue && (r_addr == LAST_ADDR)) begin
          w_state_next = ST_DRAIN;
        end else begin
          w_state_next = ST_READ;
        end
      end
      ST_DRAIN: begin
        if (w_pop & out_last) begin
          w_state_next = ST_IDLE;
          w_done       = 1'b1;
        end else begin
          w_state_next = ST_DRAIN;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Bank history, address counter and the single outstanding BRAM read.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_bank_q        <= 1'b0;
      r_addr          <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_bank_q        <= current_bank;
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue & (r_addr == LAST_ADDR);
      if (w_start) begin
        r_addr <= '0;
      end else if (w_issue && (r_addr != LAST_ADDR)) begin
        r_addr <= r_addr + SAMPLE_BITS'(1);
      end
    end
  end

  // Frame status: bank being read, busy flag and sticky overrun.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_out_bank <= 1'b0;
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_start) begin
        r_out_bank <= ~current_bank;
        r_busy     <= 1'b1;
      end else if (w_done) begin
        r_busy <= 1'b0;
      end
      // A swap outside IDLE is dropped; the frame in progress is left untouched.
      if (w_swap && (r_state != ST_IDLE)) begin
        r_overrun <= 1'b1;
      end
    end
  end

  sample_skid_buffer u_skid (
    .sys_clk (sys_clk),
    .rst     (rst),
    .i_push  (r_inflight),
    .i_data  (read_data),
    .i_last  (r_inflight_last),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (out_data),
    .o_last  (out_last),
    .o_count (w_count)
  );

  assign read_address = r_addr;
  assign out_bank     = r_out_bank;
  assign busy         = r_busy;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_sample_bank_reader.sv
// Scoreboard bench for sample_bank_reader: stimulus queues the expected frame,
// a negedge monitor pops and compares every accepted sample.
module tb_sample_bank_reader;
  import sample_bank_reader_pkg::*;

  logic                   sys_clk = 1'b0;
  logic                   rst;
  logic                   en;
  logic                   current_bank;
  logic [SAMPLE_BITS-1:0] read_address;
  logic [SAMPLE_W-1:0]    read_data;
  logic [SAMPLE_W-1:0]    out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_last;
  logic                   out_bank;
  logic                   busy;
  logic                   overrun;

  typedef struct packed {
    logic [SAMPLE_W-1:0] data;
    logic                last;
    logic                bank;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   accepted = 0;

  sample_bank_reader dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .en           (en),
    .current_bank (current_bank),
    .read_address (read_address),
    .read_data    (read_data),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .out_bank     (out_bank),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 sys_clk = ~sys_clk;

  // BRAM model: one-cycle read latency, contents = low byte of the address.
  always @(posedge sys_clk) read_data <= read_address[7:0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic push_frame(input logic bank);
    exp_t e;
    for (int i = 0; i < NUM_SAMPLES; i++) begin
      e.data = SAMPLE_W'(i);
      e.last = (i == NUM_SAMPLES - 1);
      e.bank = bank;
      q.push_back(e);
    end
  endtask

  task automatic toggle_bank(input bit expect_frame);
    current_bank = ~current_bank;
    if (expect_frame) push_frame(~current_bank);
  endtask

  task automatic wait_remaining(input int n, input bit rnd, input string name);
    int cyc;
    cyc = 0;
    while (q.size() > n && cyc < 4000) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      tick(1);
      cyc++;
    end
    if (rnd) out_ready = 1'b1;
    check({name, "_timeout"}, 32'(q.size() > n), 32'd0);
  endtask

  task automatic wait_frame_done(input bit rnd, input string name);
    int cyc;
    wait_remaining(0, rnd, name);
    cyc = 0;
    while (busy && cyc < 10) begin
      tick(1);
      cyc++;
    end
    check({name, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_addr"},    32'(read_address), 32'd0);
    check({name, "_valid"},   32'(out_valid),    32'd0);
    check({name, "_last"},    32'(out_last),     32'd0);
    check({name, "_bank"},    32'(out_bank),     32'd0);
    check({name, "_busy"},    32'(busy),         32'd0);
    check({name, "_overrun"}, 32'(overrun),      32'd0);
    check({name, "_data"},    32'(out_data),     32'd0);
  endtask

  // Monitor: compares each accepted sample against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (rst) begin
        accepted = 0;
      end else begin
        if (busy) check("addr_ahead", 32'(int'(read_address) > accepted + 2), 32'd0);
        check("last_without_valid", 32'(out_last & ~out_valid), 32'd0);
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_sample: got data %0h last %0b with nothing expected", out_data, out_last);
          end else begin
            e = q.pop_front();
            check("sample", 32'({out_data, out_last, out_bank}), 32'(e));
            accepted = out_last ? 0 : accepted + 1;
          end
        end
      end
    end
  end

  initial begin
    int cyc;
    rst = 1'b1; en = 1'b0; current_bank = 1'b0; out_ready = 1'b0;
    tick(2);
    check_all_zero("reset");
    rst = 1'b0;
    tick(2);

    // Full-rate frame: latency, gapless stream, last flag on sample 511.
    en = 1'b1; out_ready = 1'b1;
    toggle_bank(1'b1);
    tick(1);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_addr0", 32'(read_address), 32'd0);
    tick(1);
    check("t1_valid_early", 32'(out_valid), 32'd0);
    tick(1);
    check("t1_valid_first", 32'(out_valid), 32'd1);
    check("t1_bank", 32'(out_bank), 32'd0);
    tick(511);
    check("t1_valid_at_last", 32'(out_valid), 32'd1);
    check("t1_last_flag", 32'(out_last), 32'd1);
    check("t1_last_data", 32'(out_data), 32'hFF);
    tick(1);
    check("t1_valid_after", 32'(out_valid), 32'd0);
    check("t1_busy_after", 32'(busy), 32'd0);
    check("t1_queue_empty", 32'(q.size()), 32'd0);
    check("t1_overrun", 32'(overrun), 32'd0);

    // Random back-pressure frame.
    toggle_bank(1'b1);
    wait_frame_done(1'b1, "t2");
    check("t2_overrun", 32'(overrun), 32'd0);

    // Swap at sample 100: sticky overrun, frame completes, no second frame.
    toggle_bank(1'b1);
    wait_remaining(NUM_SAMPLES - 100, 1'b0, "t3_reach100");
    toggle_bank(1'b0);
    tick(1);
    check("t3_overrun_set", 32'(overrun), 32'd1);
    wait_frame_done(1'b0, "t3");
    check("t3_overrun_sticky", 32'(overrun), 32'd1);
    tick(10);
    check("t3_no_second_busy", 32'(busy), 32'd0);
    check("t3_no_second_valid", 32'(out_valid), 32'd0);

    // Enable pause at address 300.
    toggle_bank(1'b1);
    cyc = 0;
    while (read_address != SAMPLE_BITS'(300) && cyc < 2000) begin
      tick(1);
      cyc++;
    end
    check("t4_reach300", 32'(read_address), 32'd300);
    en = 1'b0;
    tick(10);
    check("t4_addr_hold", 32'(read_address), 32'd300);
    check("t4_drained", 32'(out_valid), 32'd0);
    check("t4_remaining", 32'(q.size()), 32'(NUM_SAMPLES - 300));
    en = 1'b1;
    wait_frame_done(1'b0, "t4");

    // Reset at sample 200, then a fresh frame from address 0.
    toggle_bank(1'b1);
    wait_remaining(NUM_SAMPLES - 200, 1'b0, "t5_reach200");
    rst = 1'b1;
    #1;
    check_all_zero("t5_abort");
    q.delete();
    current_bank = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(5);
    check("t5_idle_busy", 32'(busy), 32'd0);
    check("t5_idle_valid", 32'(out_valid), 32'd0);
    toggle_bank(1'b1);
    tick(1);
    check("t5_restart_addr", 32'(read_address), 32'd0);
    check("t5_restart_busy", 32'(busy), 32'd1);
    wait_frame_done(1'b0, "t5");
    check("t5_overrun", 32'(overrun), 32'd0);

    // Swap with en low is ignored; the next swap starts normally.
    en = 1'b0;
    toggle_bank(1'b0);
    tick(1);
    en = 1'b1;
    tick(5);
    check("t6_ignored_busy", 32'(busy), 32'd0);
    check("t6_ignored_valid", 32'(out_valid), 32'd0);
    toggle_bank(1'b1);
    tick(1);
    check("t6_start_busy", 32'(busy), 32'd1);
    wait_frame_done(1'b0, "t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
